// File: rtl/macc_result_pkg.sv
// Shared types and constants for the hls_macc result collector.
// MACC_RESULT_CHECKSUM_EN appends an XOR checksum word to every packet.
package macc_result_pkg;

`ifdef MACC_RESULT_CHECKSUM_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  localparam int SEQ_LSB   = 16;
  localparam int FLAG_13   = 0;
  localparam int FLAG_30   = 1;
  localparam int FLAG_31   = 2;
  localparam int HDR_SEQ_W = 16;
  localparam int IDX_W     = 3;

  typedef struct packed {
    logic [2:0]           flags;
    logic [HDR_SEQ_W-1:0] seq;
    logic [31:0]          out13;
    logic [31:0]          out30;
    logic [31:0]          out31;
    logic [31:0]          ret;
  } rec_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_t;

  function automatic logic [31:0] header_word(input rec_t r);
    logic [31:0] w;
    w = 32'd0;
    w[SEQ_LSB +: HDR_SEQ_W] = r.seq;
    w[FLAG_13] = r.flags[FLAG_13];
    w[FLAG_30] = r.flags[FLAG_30];
    w[FLAG_31] = r.flags[FLAG_31];
    return w;
  endfunction

  function automatic logic [31:0] rec_word(input rec_t r, input logic [IDX_W-1:0] idx);
    logic [31:0] w;
    case (idx)
      3'd0:    w = header_word(r);
      3'd1:    w = r.out13;
      3'd2:    w = r.out30;
      3'd3:    w = r.out31;
      3'd4:    w = r.ret;
`ifdef MACC_RESULT_CHECKSUM_EN
      3'd5:    w = header_word(r) ^ r.out13 ^ r.out30 ^ r.out31 ^ r.ret;
`endif
      default: w = 32'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/macc_rec_fifo.sv
// Single-clock record FIFO; a pop in the same cycle frees a slot for a push
// even when the FIFO is full.
module macc_rec_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         push_ok,
  output logic         full,
  output logic         empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == CNT_W'(0));
  assign do_pop  = pop && !empty;
  assign push_ok = push && (!full || do_pop);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/macc_result_collector.sv
// Collects hls_macc per-invocation results into records and streams them as packets.
// Define MACC_RESULT_CHECKSUM_EN for a trailing XOR checksum word (NW=6).
module macc_result_collector
  import macc_result_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 16
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic [31:0] k_out13,
  input  logic        k_out13_vld,
  input  logic [31:0] k_out30,
  input  logic        k_out30_vld,
  input  logic [31:0] k_out31,
  input  logic        k_out31_vld,
  input  logic [31:0] k_ret,
  input  logic        k_done,
  output logic        full_stall,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [7:0]  drop_cnt
);

  localparam int REC_W = $bits(rec_t);

  logic [31:0]      sh13_q, sh13_d, sh30_q, sh30_d, sh31_q, sh31_d;
  logic [2:0]       flags_q, flags_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [7:0]       drop_q, drop_d;
  rec_t             commit_rec, head_rec, cur_q, cur_d;
  ser_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [REC_W-1:0] fifo_rd_data;
  logic             fifo_full, fifo_empty, fifo_pop, fifo_push_ok;

  assign head_rec   = fifo_rd_data;
  assign full_stall = fifo_full;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign drop_cnt   = drop_q;

  // A strobe coinciding with k_done bypasses its shadow; shadows are zero when flag is clear.
  always_comb begin
    commit_rec       = '0;
    commit_rec.flags = flags_q | {k_out31_vld, k_out30_vld, k_out13_vld};
    commit_rec.seq   = HDR_SEQ_W'(seq_q);
    commit_rec.out13 = k_out13_vld ? k_out13 : sh13_q;
    commit_rec.out30 = k_out30_vld ? k_out30 : sh30_q;
    commit_rec.out31 = k_out31_vld ? k_out31 : sh31_q;
    commit_rec.ret   = k_ret;
  end

  always_comb begin
    sh13_d  = sh13_q;
    sh30_d  = sh30_q;
    sh31_d  = sh31_q;
    flags_d = flags_q;
    seq_d   = seq_q;
    drop_d  = drop_q;
    if (k_done) begin
      sh13_d  = 32'd0;
      sh30_d  = 32'd0;
      sh31_d  = 32'd0;
      flags_d = 3'b000;
      seq_d   = seq_q + SEQ_W'(1);
    end else begin
      sh13_d  = k_out13_vld ? k_out13 : sh13_q;
      sh30_d  = k_out30_vld ? k_out30 : sh30_q;
      sh31_d  = k_out31_vld ? k_out31 : sh31_q;
      flags_d = flags_q | {k_out31_vld, k_out30_vld, k_out13_vld};
      seq_d   = seq_q;
    end
    if (k_done && !fifo_push_ok && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  macc_rec_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .push    (k_done),
    .wr_data (commit_rec),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .push_ok (fifo_push_ok),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The head record stays in the FIFO until its last word is accepted.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cur_d    = cur_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          cur_d   = head_rec;
          idx_d   = '0;
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (m_valid_q && m_ready) begin
          if (idx_q == IDX_W'(NW - 1)) begin
            fifo_pop = 1'b1;
            idx_d    = '0;
            state_d  = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    m_valid_d = (state_d == S_SEND);
    if (m_valid_d) begin
      m_data_d = rec_word(cur_d, idx_d);
      m_last_d = (idx_d == IDX_W'(NW - 1));
    end else begin
      m_data_d = 32'd0;
      m_last_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sh13_q    <= 32'd0;
      sh30_q    <= 32'd0;
      sh31_q    <= 32'd0;
      flags_q   <= 3'b000;
      seq_q     <= '0;
      drop_q    <= 8'd0;
      cur_q     <= '0;
      state_q   <= S_IDLE;
      idx_q     <= '0;
      m_data_q  <= 32'd0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      sh13_q    <= sh13_d;
      sh30_q    <= sh30_d;
      sh31_q    <= sh31_d;
      flags_q   <= flags_d;
      seq_q     <= seq_d;
      drop_q    <= drop_d;
      cur_q     <= cur_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

endmodule

// File: tb/tb_macc_result_collector.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_macc_result_collector;

  localparam int DEPTH = 4;
`ifdef MACC_RESULT_CHECKSUM_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [31:0] k_out13 = 32'd0, k_out30 = 32'd0, k_out31 = 32'd0, k_ret = 32'd0;
  logic        k_out13_vld = 1'b0, k_out30_vld = 1'b0, k_out31_vld = 1'b0, k_done = 1'b0;
  logic        full_stall, m_valid, m_last;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [7:0]  drop_cnt;

  always #5 ap_clk = ~ap_clk;

  macc_result_collector #(.DEPTH(DEPTH), .SEQ_W(16)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .k_out13     (k_out13),
    .k_out13_vld (k_out13_vld),
    .k_out30     (k_out30),
    .k_out30_vld (k_out30_vld),
    .k_out31     (k_out31),
    .k_out31_vld (k_out31_vld),
    .k_ret       (k_ret),
    .k_done      (k_done),
    .full_stall  (full_stall),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .drop_cnt    (drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: committed-but-unsent words in order, records still occupying the FIFO.
  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  logic        got_last[$];
  int          rec_cnt = 0;
  int          widx = 0;
  int          mdrop = 0;
  logic [15:0] mseq = 16'd0;
  logic [2:0]  mflags = 3'b000;
  logic [31:0] m13 = 32'd0, m30 = 32'd0, m31 = 32'd0;
  logic        stalled = 1'b0;
  logic [31:0] stall_data = 32'd0;
  logic        stall_last = 1'b0;
  logic [2:0]  f;
  logic [31:0] v13, v30, v31, hdr;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      exp_q.delete();
      rec_cnt = 0; widx = 0; mdrop = 0; mseq = 16'd0; mflags = 3'b000;
      stalled = 1'b0;
    end else begin
      check("full_stall", 32'(full_stall), 32'(rec_cnt == DEPTH));
      check("drop_cnt", 32'(drop_cnt), 32'(mdrop));
      if (rec_cnt == 0) check("idle_valid", 32'(m_valid), 32'd0);
      if (stalled) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", m_data, stall_data);
        check("hold_last", 32'(m_last), 32'(stall_last));
      end
      if (m_valid && m_ready && exp_q.size() > 0) begin
        check("m_data", m_data, exp_q[0]);
        check("m_last", 32'(m_last), 32'(widx == NW - 1));
        got.push_back(m_data);
        got_last.push_back(m_last);
        void'(exp_q.pop_front());
        if (widx == NW - 1) begin
          widx = 0;
          rec_cnt--;
        end else begin
          widx++;
        end
      end
      stalled    = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;

      if (k_done) begin
        f   = mflags | {k_out31_vld, k_out30_vld, k_out13_vld};
        v13 = k_out13_vld ? k_out13 : (mflags[0] ? m13 : 32'd0);
        v30 = k_out30_vld ? k_out30 : (mflags[1] ? m30 : 32'd0);
        v31 = k_out31_vld ? k_out31 : (mflags[2] ? m31 : 32'd0);
        hdr = {mseq, 13'd0, f};
        if (rec_cnt < DEPTH) begin
          exp_q.push_back(hdr);
          exp_q.push_back(v13);
          exp_q.push_back(v30);
          exp_q.push_back(v31);
          exp_q.push_back(k_ret);
          if (NW == 6) exp_q.push_back(hdr ^ v13 ^ v30 ^ v31 ^ k_ret);
          rec_cnt++;
        end else if (mdrop < 255) begin
          mdrop++;
        end
        mseq   = mseq + 16'd1;
        mflags = 3'b000;
      end else begin
        if (k_out13_vld) begin m13 = k_out13; mflags[0] = 1'b1; end
        if (k_out30_vld) begin m30 = k_out30; mflags[1] = 1'b1; end
        if (k_out31_vld) begin m31 = k_out31; mflags[2] = 1'b1; end
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle_inputs();
    k_out13_vld = 1'b0; k_out30_vld = 1'b0; k_out31_vld = 1'b0; k_done = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    m_ready  = 1'b0;
    ap_rst_n = 1'b0;
    repeat (2) tick();
    ap_rst_n = 1'b1;
    tick();
    got.delete();
    got_last.delete();
  endtask

  task automatic wait_words(input int n, input string name);
    int budget = 200;
    while (got.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    if (got.size() < n) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout, got %0d words expected %0d", name, got.size(), n);
    end
  endtask

  task automatic commit_only(input logic [31:0] ret);
    k_ret = ret; k_done = 1'b1;
    tick();
    k_done = 1'b0;
  endtask

  initial begin
    int budget;
    ap_rst_n = 1'b0;
    #3;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", m_data, 32'd0);
    check("rst_stall", 32'(full_stall), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);

    // Full strobe set, out31 arriving with done
    do_reset();
    m_ready = 1'b1;
    k_out13 = 32'h10; k_out13_vld = 1'b1; tick(); k_out13_vld = 1'b0;
    k_out30 = 32'h20; k_out30_vld = 1'b1; tick(); k_out30_vld = 1'b0;
    k_out31 = 32'h30; k_out31_vld = 1'b1; k_ret = 32'h40; k_done = 1'b1;
    tick();
    idle_inputs();
    check("lat_t1_valid", 32'(m_valid), 32'd0);
    tick();
    check("lat_t2_valid", 32'(m_valid), 32'd1);
    check("lat_t2_w0", m_data, 32'h00000007);
    wait_words(NW, "s1_words");
    check("s1_w0", got[0], 32'h00000007);
    check("s1_w1", got[1], 32'h10);
    check("s1_w2", got[2], 32'h20);
    check("s1_w3", got[3], 32'h30);
    check("s1_w4", got[4], 32'h40);
    check("s1_w4_last", 32'(got_last[4]), 32'(NW == 5));
    if (NW == 6) begin
      check("s1_w5_csum", got[5], 32'h00000047);
      check("s1_w5_last", 32'(got_last[5]), 32'd1);
    end

    // No out30 strobe, two invocations
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      k_out13 = 32'h11; k_out13_vld = 1'b1; tick(); k_out13_vld = 1'b0;
      k_out31 = 32'h31; k_out31_vld = 1'b1; k_ret = 32'h41; k_done = 1'b1;
      tick();
      idle_inputs();
    end
    wait_words(2 * NW, "s2_words");
    check("s2_hdr0", got[0], 32'h00000005);
    check("s2_w2", got[2], 32'd0);
    check("s2_hdr1", got[NW], 32'h00010005);
    check("s2_w2b", got[NW + 2], 32'd0);

    // Back-pressure and overflow
    do_reset();
    for (int i = 0; i < 4; i++) begin
      commit_only(32'(i));
      if (i == 2) check("s3_stall_3", 32'(full_stall), 32'd0);
    end
    check("s3_stall_4", 32'(full_stall), 32'd1);
    commit_only(32'hdead);
    check("s3_drop", 32'(drop_cnt), 32'd1);
    m_ready = 1'b1;
    wait_words(4 * NW, "s3_drain");
    commit_only(32'h55);
    wait_words(5 * NW, "s3_next");
    check("s3_hdr0", got[0], 32'h00000000);
    check("s3_hdr1", got[NW], 32'h00010000);
    check("s3_hdr2", got[2 * NW], 32'h00020000);
    check("s3_hdr3", got[3 * NW], 32'h00030000);
    check("s3_hdr5", got[4 * NW], 32'h00050000);
    check("s3_ret5", got[4 * NW + 4], 32'h55);

    // Push and pop in the same cycle while full
    do_reset();
    for (int i = 0; i < 4; i++) commit_only(32'(i + 8));
    check("s4_full", 32'(full_stall), 32'd1);
    m_ready = 1'b1;
    budget = 50;
    while (!(m_valid && m_last) && budget > 0) begin
      tick();
      budget--;
    end
    check("s4_reach_last", 32'(m_valid && m_last), 32'd1);
    commit_only(32'h99);
    check("s4_drop", 32'(drop_cnt), 32'd0);
    check("s4_still_full", 32'(full_stall), 32'd1);
    wait_words(5 * NW, "s4_drain");
    check("s4_hdr4", got[4 * NW], 32'h00040000);
    check("s4_ret4", got[4 * NW + 4], 32'h99);

    // Reset in the middle of W2 with ready toggling
    do_reset();
    k_out30 = 32'h77; k_out30_vld = 1'b1; tick(); k_out30_vld = 1'b0;
    commit_only(32'h1);
    commit_only(32'h2);
    budget = 200;
    while (!(m_valid && widx == 2 && rec_cnt > 0) && budget > 0) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      budget--;
    end
    check("s5_reach_w2", 32'(m_valid && widx == 2), 32'd1);
    m_ready = 1'($urandom_range(0, 1));
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("s5_async_valid", 32'(m_valid), 32'd0);
    check("s5_async_last", 32'(m_last), 32'd0);
    check("s5_async_stall", 32'(full_stall), 32'd0);
    got.delete();
    got_last.delete();
    repeat (2) tick();
    ap_rst_n = 1'b1;
    m_ready  = 1'b1;
    repeat (10) tick();
    check("s5_no_stale", 32'(got.size()), 32'd0);
    k_out13 = 32'h5; k_out13_vld = 1'b1; k_done = 1'b1; k_ret = 32'h6;
    tick();
    idle_inputs();
    wait_words(NW, "s5_words");
    check("s5_hdr", got[0], 32'h00000001);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      k_out13 = $urandom; k_out30 = $urandom; k_out31 = $urandom; k_ret = $urandom;
      k_out13_vld = ($urandom_range(0, 3) == 0);
      k_out30_vld = ($urandom_range(0, 3) == 0);
      k_out31_vld = ($urandom_range(0, 3) == 0);
      k_done      = ($urandom_range(0, 5) == 0);
      if (c < 1500) m_ready = ($urandom_range(0, 3) != 0);
      else          m_ready = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle_inputs();
    m_ready = 1'b1;
    budget = 200;
    while (rec_cnt > 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("rand_drained", 32'(rec_cnt), 32'd0);
    check("rand_drop_seen", 32'(mdrop > 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
